core_monitor_sel_arb: RTL and testbench

- Generates the 2-bit core select that steers one core's instruction-hash stream (four_bit_hash, new_inst_signal, processor_reset_seq, sp_pkt_done, sp_interrupt_wire) to the shared hardware monitor.
- Sits directly upstream of the 4:1 core-to-monitor mux and drives its select input.
- Binds the monitor to one core for a whole packet and stalls other cores that start a packet meanwhile.
- Arbitrates round-robin among waiting cores.

---
 rtl/core_monitor_sel_arb_pkg.sv | 14 +
 rtl/core_monitor_sel_arb_rr_pick4.sv | 21 ++
 rtl/core_monitor_sel_arb.sv | 113 +++++++++++
 tb/tb_core_monitor_sel_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_monitor_sel_arb_pkg.sv
// Shared types and constants for the core-to-monitor select arbiter.
package core_monitor_sel_arb_pkg;

  localparam int NUM_CORES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/core_monitor_sel_arb_rr_pick4.sv
// Combinational 4-way round-robin picker: first pending core after i_last, wrapping.
module rr_pick4
  import core_monitor_sel_arb_pkg::*;
(
  input  logic [NUM_CORES-1:0] i_pending,
  input  logic [SEL_W-1:0]     i_last,
  output logic [SEL_W-1:0]     o_winner,
  output logic                 o_any
);

  assign o_any = |i_pending;

  // Scan from the farthest offset down so the nearest pending core after i_last wins.
  always_comb begin
    o_winner = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      if (i_pending[i_last + SEL_W'(k)]) o_winner = i_last + SEL_W'(k);
    end
  end

endmodule

// File: rtl/core_monitor_sel_arb.sv
// Binds the shared hardware monitor to one core per packet and drives the 4:1 mux select.
module core_monitor_sel_arb
  import core_monitor_sel_arb_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CORES-1:0] pkt_start,
  input  logic [NUM_CORES-1:0] sp_pkt_done,
  input  logic [NUM_CORES-1:0] sp_interrupt_wire,
  input  logic                 monitor_ready,
  output logic [SEL_W-1:0]     sel,
  output logic                 sel_valid,
  output logic                 mon_load,
  output logic [NUM_CORES-1:0] core_stall,
  output logic                 timeout_err
);

  // A zero hold length still needs one drain cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [SEL_W-1:0]     r_last;
  logic [NUM_CORES-1:0] r_pending;
  logic [SEL_W-1:0]     r_sel;
  logic                 r_sel_valid;
  logic                 r_mon_load;
  logic [NUM_CORES-1:0] r_core_stall;
  logic                 r_timeout_err;

  logic [SEL_W-1:0]     w_win;
  logic                 w_any;
  logic                 w_grant;
  logic [NUM_CORES-1:0] w_grant_mask;
  logic                 w_end_sel;
  logic                 w_timeout;
  logic [CNT_W-1:0]     w_cnt_inc;

  rr_pick4 u_pick (
    .i_pending (r_pending),
    .i_last    (r_last),
    .o_winner  (w_win),
    .o_any     (w_any)
  );

  assign w_grant      = (r_state == ST_IDLE) && w_any && monitor_ready;
  assign w_grant_mask = w_grant ? (NUM_CORES'(1) << w_win) : '0;
  assign w_end_sel    = sp_pkt_done[r_sel] | sp_interrupt_wire[r_sel];
  assign w_timeout    = (r_cnt == TO_LAST);
  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_last        <= SEL_W'(NUM_CORES - 1);
      r_pending     <= '0;
      r_sel         <= '0;
      r_sel_valid   <= 1'b0;
      r_mon_load    <= 1'b0;
      r_core_stall  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // A fresh pkt_start re-queues a core even in its own grant cycle.
      r_pending     <= (r_pending & ~w_grant_mask) | pkt_start;
      r_core_stall  <= r_pending;
      r_mon_load    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_sel      <= w_win;
            r_last     <= w_win;
            r_mon_load <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt       <= '0;
          r_sel_valid <= 1'b1;
          r_state     <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_end_sel || w_timeout) begin
            r_cnt         <= '0;
            r_sel_valid   <= 1'b0;
            r_timeout_err <= !w_end_sel;
            r_state       <= ST_HOLD;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_HOLD: begin
          r_cnt <= w_cnt_inc;
          if ((r_cnt >= HOLD_LAST) && monitor_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel         = r_sel;
  assign sel_valid   = r_sel_valid;
  assign mon_load    = r_mon_load;
  assign core_stall  = r_core_stall;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_core_monitor_sel_arb.sv
// Directed bench for core_monitor_sel_arb (HOLD_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_core_monitor_sel_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] pkt_start;
  logic [3:0] sp_pkt_done;
  logic [3:0] sp_interrupt_wire;
  logic       monitor_ready;
  logic [1:0] sel;
  logic       sel_valid;
  logic       mon_load;
  logic [3:0] core_stall;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  core_monitor_sel_arb #(
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pkt_start         (pkt_start),
    .sp_pkt_done       (sp_pkt_done),
    .sp_interrupt_wire (sp_interrupt_wire),
    .monitor_ready     (monitor_ready),
    .sel               (sel),
    .sel_valid         (sel_valid),
    .mon_load          (mon_load),
    .core_stall        (core_stall),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_load(input int exp_wait, input logic [1:0] exp_sel);
    int n;
    n = 0;
    while (mon_load !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("load_wait", 32'(n), 32'(exp_wait));
    chk("load_sel", 32'(sel), 32'(exp_sel));
  endtask

  // Serve one core: LOAD, one ACTIVE cycle, then its own done.
  task automatic serve(input logic [1:0] core, input logic [3:0] st_load,
                       input logic [3:0] st_act, input int exp_wait);
    wait_load(exp_wait, core);
    chk("stall_load", 32'(core_stall), 32'(st_load));
    tick();
    chk("active_valid", 32'(sel_valid), 32'd1);
    chk("stall_active", 32'(core_stall), 32'(st_act));
    sp_pkt_done = 4'b0001 << core;
    tick();
    sp_pkt_done = 4'b0000;
    chk("hold_valid", 32'(sel_valid), 32'd0);
    chk("hold_sel", 32'(sel), 32'(core));
  endtask

  initial begin
    int n;
    int to_cnt;
    logic seen;
    reset_n           = 1'b0;
    pkt_start         = 4'b0000;
    sp_pkt_done       = 4'b0000;
    sp_interrupt_wire = 4'b0000;
    monitor_ready     = 1'b1;
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(sel_valid), 32'd0);
    chk("rst_load", 32'(mon_load), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_to", 32'(timeout_err), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single request for core 2: LOAD two cycles after pkt_start, valid one later.
    pkt_start = 4'b0100;
    tick();
    pkt_start = 4'b0000;
    chk("sr_noload", 32'(mon_load), 32'd0);
    tick();
    chk("sr_load", 32'(mon_load), 32'd1);
    chk("sr_sel", 32'(sel), 32'd2);
    chk("sr_valid_ld", 32'(sel_valid), 32'd0);
    chk("sr_stall_ld", 32'(core_stall), 32'h4);
    tick();
    chk("sr_load_off", 32'(mon_load), 32'd0);
    chk("sr_valid", 32'(sel_valid), 32'd1);
    chk("sr_stall_rel", 32'(core_stall), 32'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("sr_still_valid", 32'(sel_valid), 32'd1);
    sp_pkt_done = 4'b0100;
    tick();
    sp_pkt_done = 4'b0000;
    chk("sr_hold", 32'(sel_valid), 32'd0);
    chk("sr_to", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("sr_sel_kept", 32'(sel), 32'd2);

    // Contention from reset-like last_grant=2: order 3,0,1,2 after core 2 was last.
    // (last_grant is now 2, so search begins at 3.)
    pkt_start = 4'b1111;
    tick();
    pkt_start = 4'b0000;
    serve(2'd3, 4'b1111, 4'b0111, 1);
    serve(2'd0, 4'b0111, 4'b0110, 5);
    serve(2'd1, 4'b0110, 4'b0100, 5);
    serve(2'd2, 4'b0100, 4'b0000, 5);

    // Foreign done/interrupt ignored; own interrupt ends the window.
    pkt_start = 4'b0010;
    tick();
    pkt_start = 4'b0000;
    wait_load(4, 2'd1);
    tick();
    chk("fd_valid", 32'(sel_valid), 32'd1);
    sp_pkt_done       = 4'b0001;
    sp_interrupt_wire = 4'b1101;
    tick();
    sp_pkt_done       = 4'b0000;
    chk("fd_ignored", 32'(sel_valid), 32'd1);
    sp_interrupt_wire = 4'b0010;
    tick();
    sp_interrupt_wire = 4'b0000;
    chk("fd_int_hold", 32'(sel_valid), 32'd0);
    chk("fd_sel", 32'(sel), 32'd1);

    // Watchdog: exactly 16 ACTIVE cycles then one timeout pulse.
    pkt_start = 4'b0001;
    tick();
    pkt_start = 4'b0000;
    wait_load(4, 2'd0);
    tick();
    n = 0;
    to_cnt = 0;
    while (sel_valid === 1'b1 && n < 40) begin
      if (timeout_err === 1'b1) to_cnt++;
      tick();
      n++;
    end
    chk("wd_active_len", 32'(n), 32'd16);
    chk("wd_no_early_to", 32'(to_cnt), 32'd0);
    chk("wd_to_pulse", 32'(timeout_err), 32'd1);

    // monitor_ready low keeps HOLD; core 3 waits.
    monitor_ready = 1'b0;
    pkt_start = 4'b1000;
    tick();
    pkt_start = 4'b0000;
    chk("wd_to_single", 32'(timeout_err), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      seen = seen | mon_load;
      tick();
    end
    chk("mr_no_load", 32'(seen | mon_load), 32'd0);
    chk("mr_sel", 32'(sel), 32'd0);
    chk("mr_stall", 32'(core_stall), 32'h8);
    monitor_ready = 1'b1;
    tick();
    chk("mr_idle", 32'(mon_load), 32'd0);
    tick();
    chk("mr_load", 32'(mon_load), 32'd1);
    chk("mr_sel3", 32'(sel), 32'd3);
    tick();

    // Mid-operation reset with pending=1010.
    pkt_start = 4'b1010;
    tick();
    pkt_start = 4'b0000;
    tick();
    chk("mrst_pre_stall", 32'(core_stall), 32'ha);
    chk("mrst_pre_valid", 32'(sel_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mrst_sel", 32'(sel), 32'd0);
    chk("mrst_valid", 32'(sel_valid), 32'd0);
    chk("mrst_stall", 32'(core_stall), 32'h0);
    chk("mrst_load", 32'(mon_load), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | mon_load | sel_valid | (|core_stall);
    end
    chk("mrst_no_grant", 32'(seen), 32'd0);
    pkt_start = 4'b0100;
    tick();
    pkt_start = 4'b0000;
    wait_load(1, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
